// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one two-cycle-issue ALU between requesters A and B.
// Sequences opcode/operand issue, waits for done with a timeout, and returns the response.
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_a,
    input  logic [OPW-1:0]   opcode_a,
    input  logic [WIDTH-1:0] opnd_a0,
    input  logic [WIDTH-1:0] opnd_a1,
    output logic             gnt_a,
    output logic             rsp_valid_a,

    input  logic             req_b,
    input  logic [OPW-1:0]   opcode_b,
    input  logic [WIDTH-1:0] opnd_b0,
    input  logic [WIDTH-1:0] opnd_b1,
    output logic             gnt_b,
    output logic             rsp_valid_b,

    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic             busy,

    output logic             alu_opcode_valid,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_data,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow
);

    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ptr_b;
    logic             r_owner_b;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer;
    logic [WIDTH-1:0] r_opnd1;

    logic             w_grant;
    logic             w_pick_b;
    logic             w_resp;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_opv;
    logic [OPW-1:0]   w_opcode;
    logic [WIDTH-1:0] w_data;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_timer      = r_timer;
        w_grant      = 1'b0;
        w_pick_b     = req_b && (!req_a || r_ptr_b);
        w_resp       = 1'b0;
        w_gnt_a      = 1'b0;
        w_gnt_b      = 1'b0;
        w_opv        = 1'b0;
        w_opcode     = '0;
        w_data       = '0;

        case (r_state)
            S_IDLE: begin
                if (req_a || req_b) begin
                    w_grant      = 1'b1;
                    w_next_state = S_SEND_A;
                    w_gnt_a      = !w_pick_b;
                    w_gnt_b      = w_pick_b;
                    w_opv        = 1'b1;
                    w_opcode     = w_pick_b ? opcode_b : opcode_a;
                    w_data       = w_pick_b ? opnd_b0 : opnd_a0;
                end
            end
            S_SEND_A: begin
                w_next_state = S_SEND_B;
                w_data       = r_opnd1;
            end
            S_SEND_B: begin
                w_next_state = S_WAIT;
                w_timer      = '0;
            end
            S_WAIT: begin
                // A done on the last timeout cycle still counts as a normal completion.
                if (alu_done || (r_timer == TIMER_LAST)) begin
                    w_resp       = 1'b1;
                    w_next_state = S_RESP;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr_b <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_timer;
            if (w_grant) r_ptr_b <= !w_pick_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_b        <= 1'b0;
            gnt_a            <= 1'b0;
            gnt_b            <= 1'b0;
            rsp_valid_a      <= 1'b0;
            rsp_valid_b      <= 1'b0;
            rsp_result       <= '0;
            rsp_overflow     <= 1'b0;
            rsp_err          <= 1'b0;
            busy             <= 1'b0;
            alu_opcode_valid <= 1'b0;
            alu_opcode       <= '0;
            alu_data         <= '0;
        end else begin
            gnt_a            <= w_gnt_a;
            gnt_b            <= w_gnt_b;
            alu_opcode_valid <= w_opv;
            alu_opcode       <= w_opcode;
            alu_data         <= w_data;
            busy             <= (w_next_state != S_IDLE);
            rsp_valid_a      <= w_resp && !r_owner_b;
            rsp_valid_b      <= w_resp && r_owner_b;
            if (w_grant) r_owner_b <= w_pick_b;
            if (w_resp) begin
                rsp_result   <= alu_done ? alu_result : '0;
                rsp_overflow <= alu_done && alu_overflow;
                rsp_err      <= !alu_done;
            end
        end
    end

    // NOTE: the second operand is plain data only read after a grant loads it, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_grant) r_opnd1 <= w_pick_b ? opnd_b1 : opnd_a1;
    end

endmodule
